// File: rtl/bus_memory_controller_pkg.sv
// Shared bus operation and controller state types for the bus memory controller.
package bus_memory_controller_pkg;

   localparam int unsigned NUM_CACHES   = 4;
   localparam int unsigned MEM_LATENCY  = 4;
   localparam int unsigned LINEADDRBITS = 14;

   typedef enum logic [1:0] {
      NOP       = 2'b00,
      READ      = 2'b01,
      WRITEBACK = 2'b10,
      UPDATE    = 2'b11
   } BusOp;

   typedef enum logic [2:0] {
      StIdle,
      StGrant,
      StSnoop,
      StMem,
      StFlush,
      StDone
   } BusCtlState;

endpackage

// File: rtl/bus_memory_controller_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
module bus_memory_controller_rr_arbiter
   import bus_memory_controller_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic [N-1:0] i_req,
   input  logic         i_advance,
   output logic         o_valid,
   output logic [N-1:0] o_gnt
);

   localparam int unsigned IDX_W = $clog2(N);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_cand;
   logic [IDX_W-1:0] w_idx;

   // Find the first active request at or after the pointer, wrapping around.
   always_comb begin
      o_valid = 1'b0;
      o_gnt   = '0;
      w_idx   = '0;
      w_cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = IDX_W'((32'(r_ptr) + k) % N);
         if (!o_valid && i_req[w_cand]) begin
            o_valid       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            w_idx         = w_cand;
         end
      end
   end

   // Pointer moves to the slot after the winner so the winner goes to the back of the line.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (i_advance && o_valid) begin
         r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
      end
   end

endmodule

// File: rtl/bus_memory_controller.sv
// Shared-bus owner: arbitrates cache requests, broadcasts snoops, serves fills/writebacks.
module bus_memory_controller #(
   parameter int unsigned NUM_CACHES   = 4,
   parameter int unsigned ADDRESSWIDTH = 16,
   parameter int unsigned DATABUSWIDTH = 32,
   parameter int unsigned MEM_LATENCY  = 4
) (
   input  logic                               i_clock,
   input  logic                               i_reset,
   input  logic [NUM_CACHES-1:0]              i_req,
   input  logic [2*NUM_CACHES-1:0]            i_req_op,
   input  logic [NUM_CACHES*ADDRESSWIDTH-1:0] i_req_addr,
   input  logic [NUM_CACHES*DATABUSWIDTH-1:0] i_req_wdata,
   input  logic [NUM_CACHES-1:0]              i_snoop_shared,
   input  logic [NUM_CACHES-1:0]              i_snoop_flush,
   input  logic [NUM_CACHES*DATABUSWIDTH-1:0] i_flush_data,
   output logic [NUM_CACHES-1:0]              o_gnt,
   output logic                               o_bus_rd,
   output logic                               o_bus_upd,
   output logic [ADDRESSWIDTH-1:0]            o_bus_addr,
   output logic [DATABUSWIDTH-1:0]            o_bus_data,
   output logic                               o_bus_shared,
   output logic                               o_done
);
   import bus_memory_controller_pkg::*;

   localparam int unsigned LINE_W = ADDRESSWIDTH - 2;
   localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   BusCtlState                r_state;
   BusCtlState                w_state_d;
   logic [NUM_CACHES-1:0]     r_gnt;
   BusOp                      r_op;
   logic [LINE_W-1:0]         r_line;
   logic [DATABUSWIDTH-1:0]   r_wdata;
   logic [DATABUSWIDTH-1:0]   r_data;
   logic                      r_shared;
   logic [CNT_W-1:0]          r_cnt;
   logic [DATABUSWIDTH-1:0]   r_mem [2**LINE_W];

   logic [NUM_CACHES-1:0]     w_req_valid;
   logic                      w_arb_valid;
   logic [NUM_CACHES-1:0]     w_arb_gnt;
   logic [1:0]                w_op_sel;
   logic [ADDRESSWIDTH-1:0]   w_addr_sel;
   logic [DATABUSWIDTH-1:0]   w_wdata_sel;
   logic [NUM_CACHES-1:0]     w_shared_oth;
   logic [NUM_CACHES-1:0]     w_flush_oth;
   logic [DATABUSWIDTH-1:0]   w_flush_sel;
   logic                      w_cnt_last;
   logic                      w_mem_we;
   logic                      w_unused_bytesel;

   // Requests with a NOP opcode never compete for the bus.
   always_comb begin
      w_req_valid = '0;
      for (int unsigned i = 0; i < NUM_CACHES; i++) begin
         w_req_valid[i] = i_req[i] && (i_req_op[2*i +: 2] != NOP);
      end
   end

   bus_memory_controller_rr_arbiter #(
      .N (NUM_CACHES)
   ) u_arb (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_req     (w_req_valid),
      .i_advance (r_state == StIdle),
      .o_valid   (w_arb_valid),
      .o_gnt     (w_arb_gnt)
   );

   // Steer the winner's request fields and the lowest-index flusher's data.
   always_comb begin
      w_op_sel    = '0;
      w_addr_sel  = '0;
      w_wdata_sel = '0;
      w_flush_sel = '0;
      for (int unsigned i = 0; i < NUM_CACHES; i++) begin
         if (w_arb_gnt[i]) begin
            w_op_sel    = i_req_op[2*i +: 2];
            w_addr_sel  = i_req_addr[i*ADDRESSWIDTH +: ADDRESSWIDTH];
            w_wdata_sel = i_req_wdata[i*DATABUSWIDTH +: DATABUSWIDTH];
         end
      end
      for (int i = NUM_CACHES - 1; i >= 0; i--) begin
         if (w_flush_oth[i]) w_flush_sel = i_flush_data[i*DATABUSWIDTH +: DATABUSWIDTH];
      end
   end

   // The requester never snoops its own transaction.
   assign w_shared_oth     = i_snoop_shared & ~r_gnt;
   assign w_flush_oth      = i_snoop_flush & ~r_gnt;
   assign w_cnt_last       = (r_cnt == CNT_W'(MEM_LATENCY - 1));
   assign w_mem_we         = (r_state == StMem) && w_cnt_last && (r_op == WRITEBACK);
   assign w_unused_bytesel = ^w_addr_sel[1:0];

   // FSM state register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= StIdle;
      else         r_state <= w_state_d;
   end

   // Next-state decode and bus outputs.
   always_comb begin
      w_state_d    = r_state;
      o_gnt        = '0;
      o_bus_rd     = 1'b0;
      o_bus_upd    = 1'b0;
      o_bus_addr   = '0;
      o_bus_data   = '0;
      o_bus_shared = 1'b0;
      o_done       = 1'b0;
      if (r_state != StIdle) begin
         o_gnt      = r_gnt;
         o_bus_addr = {r_line, 2'b00};
      end
      case (r_state)
         StIdle:  if (w_arb_valid) w_state_d = StGrant;
         StGrant: w_state_d = StSnoop;
         StSnoop: begin
            o_bus_rd  = (r_op == READ);
            o_bus_upd = (r_op == UPDATE);
            if (r_op == UPDATE) o_bus_data = r_wdata;
            unique case (r_op)
               READ:      w_state_d = (|w_flush_oth) ? StFlush : StMem;
               WRITEBACK: w_state_d = StMem;
               UPDATE:    w_state_d = StDone;
               NOP:       w_state_d = StDone;
            endcase
         end
         StMem:   if (w_cnt_last) w_state_d = StDone;
         StFlush: w_state_d = StDone;
         StDone: begin
            o_done       = 1'b1;
            o_bus_shared = r_shared;
            if (r_op == READ) o_bus_data = r_data;
            w_state_d    = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Transaction context: latched at arbitration, snoop results, latency count, fill data.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_gnt    <= '0;
         r_op     <= NOP;
         r_line   <= '0;
         r_wdata  <= '0;
         r_data   <= '0;
         r_shared <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_arb_valid) begin
                  r_gnt    <= w_arb_gnt;
                  r_op     <= BusOp'(w_op_sel);
                  r_line   <= w_addr_sel[ADDRESSWIDTH-1:2];
                  r_wdata  <= w_wdata_sel;
                  r_data   <= '0;
                  r_shared <= 1'b0;
                  r_cnt    <= '0;
               end
            end
            StSnoop: begin
               r_shared <= |w_shared_oth;
               if (r_op == READ && |w_flush_oth) r_data <= w_flush_sel;
            end
            StMem: begin
               if (w_cnt_last) begin
                  r_cnt <= '0;
                  if (r_op == READ) r_data <= r_mem[r_line];
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Main memory write port; contents survive reset.
   always_ff @(posedge i_clock) begin
      if (w_mem_we) r_mem[r_line] <= r_wdata;
   end

   // Owner-supplied data must come from a single snooper.
   assert property (@(posedge i_clock) disable iff (i_reset)
      (r_state == StSnoop && r_op == READ) |-> $onehot0(w_flush_oth));

   for (genvar g = 0; g < NUM_CACHES; g++) begin : g_op_chk
      // A raised request must carry a real bus operation.
      assert property (@(posedge i_clock) disable iff (i_reset)
         !(i_req[g] && i_req_op[2*g +: 2] == NOP));
   end

endmodule

// File: tb/tb_bus_memory_controller.sv
// Scoreboard bench for bus_memory_controller with a behavioural bus/memory model.
module tb_bus_memory_controller;

   localparam int N  = 4;
   localparam int ML = 4;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b1;
   logic [3:0]    i_req = '0;
   logic [7:0]    i_req_op = '0;
   logic [63:0]   i_req_addr = '0;
   logic [127:0]  i_req_wdata = '0;
   logic [3:0]    i_snoop_shared = '0;
   logic [3:0]    i_snoop_flush = '0;
   logic [127:0]  i_flush_data = '0;
   logic [3:0]    o_gnt;
   logic          o_bus_rd;
   logic          o_bus_upd;
   logic [15:0]   o_bus_addr;
   logic [31:0]   o_bus_data;
   logic          o_bus_shared;
   logic          o_done;

   bus_memory_controller #(
      .NUM_CACHES   (N),
      .ADDRESSWIDTH (16),
      .DATABUSWIDTH (32),
      .MEM_LATENCY  (ML)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_req          (i_req),
      .i_req_op       (i_req_op),
      .i_req_addr     (i_req_addr),
      .i_req_wdata    (i_req_wdata),
      .i_snoop_shared (i_snoop_shared),
      .i_snoop_flush  (i_snoop_flush),
      .i_flush_data   (i_flush_data),
      .o_gnt          (o_gnt),
      .o_bus_rd       (o_bus_rd),
      .o_bus_upd      (o_bus_upd),
      .o_bus_addr     (o_bus_addr),
      .o_bus_data     (o_bus_data),
      .o_bus_shared   (o_bus_shared),
      .o_done         (o_done)
   );

   always #5 i_clock = ~i_clock;

   int cyc = 0;
   always @(posedge i_clock) cyc <= cyc + 1;

   typedef struct {
      int          cache;
      logic [1:0]  op;
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] wdata;
      logic        shared;
      int          done_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mm [int];
   logic [13:0] pool [8];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_done   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Model: compute the expected completion from the bus rules, then drive the request.
   task automatic issue(input int c, input logic [1:0] op, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] sh, input logic [3:0] fl,
                        input logic [127:0] fd, input int extra, input bit expect_done);
      exp_t       e;
      logic [3:0] oth;
      int         lat;
      int         idx;
      oth      = ~(4'b0001 << c);
      idx      = int'(addr[15:2]);
      e.cache  = c;
      e.op     = op;
      e.addr   = addr;
      e.wdata  = wd;
      e.data   = '0;
      e.shared = |(sh & oth);
      lat      = 3 + ML;
      if (op == 2'b01) begin
         if ((fl & oth) != 4'b0) begin
            lat = 4;
            for (int k = 3; k >= 0; k--) if (fl[k] && oth[k]) e.data = fd[32*k +: 32];
         end else begin
            e.data = mm.exists(idx) ? mm[idx] : 32'h0;
         end
      end else if (op == 2'b11) begin
         lat = 3;
      end else if (expect_done) begin
         mm[idx] = wd;
      end
      e.done_cyc = cyc + lat + extra;
      i_req_op[2*c +: 2]     = op;
      i_req_addr[16*c +: 16] = addr;
      i_req_wdata[32*c +: 32] = wd;
      i_snoop_shared = sh;
      i_snoop_flush  = fl;
      i_flush_data   = fd;
      i_req[c]       = 1'b1;
      if (expect_done) sb.push_back(e);
   endtask

   // Wait (bounded) for a done pulse and drop that cache's request afterwards.
   task automatic wait_done_release();
      logic [3:0] g;
      bit         got;
      g   = '0;
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge i_clock);
         if (o_done) begin
            got = 1'b1;
            g   = o_gnt;
         end
      end
      check("done_within_bound", 64'(got), 64'd1);
      @(posedge i_clock);
      #1;
      i_req = i_req & ~g;
      if (i_req == 4'b0) begin
         i_snoop_shared = '0;
         i_snoop_flush  = '0;
      end
   endtask

   // Monitor: compare every broadcast and completion against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clock);
         if (o_bus_rd || o_bus_upd) begin
            check("snoop_has_txn", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb[0];
               check("snoop_addr", o_bus_addr, {e.addr[15:2], 2'b00});
               if (o_bus_rd) check("rd_op", e.op, 2'b01);
               if (o_bus_upd) begin
                  check("upd_op", e.op, 2'b11);
                  check("upd_data", o_bus_data, e.wdata);
               end
            end
         end
         if (o_done) begin
            n_done++;
            check("done_has_txn", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("done_gnt", o_gnt, 64'(1 << e.cache));
               check("done_cycle", cyc, e.done_cyc);
               check("done_addr", o_bus_addr, {e.addr[15:2], 2'b00});
               check("done_shared", o_bus_shared, e.shared);
               if (e.op == 2'b01) check("fill_data", o_bus_data, e.data);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [3:0]   fl;
      logic [31:0]  old;
      logic [15:0]  a;
      int           nd;
      int           idx;

      #3;
      check("reset_outputs", {o_gnt, o_bus_rd, o_bus_upd, o_bus_addr, o_bus_data,
                              o_bus_shared, o_done}, 64'd0);
      pool[0] = 14'h041;
      pool[1] = 14'h884;
      for (int j = 2; j < 8; j++) pool[j] = 14'($urandom);
      for (int j = 1; j < 8; j++) begin
         mm[int'(pool[j])]  = $urandom;
         dut.r_mem[pool[j]] = mm[int'(pool[j])];
      end
      mm[32'h41]         = 32'hDEADBEEF;
      dut.r_mem[14'h041] = 32'hDEADBEEF;
      repeat (2) @(posedge i_clock);
      #1 i_reset = 1'b0;
      @(posedge i_clock);
      #1;

      // Fill with no other holders, then fill supplied by an owner cache.
      issue(1, 2'b01, 16'h0104, 32'h0, 4'b0000, 4'b0000, 128'h0, 0, 1'b1);
      wait_done_release();
      issue(1, 2'b01, 16'h0104, 32'h0, 4'b0100, 4'b0100,
            {32'h0, 32'hCAFEF00D, 64'h0}, 0, 1'b1);
      wait_done_release();
      check("flush_mem_kept", dut.r_mem[14'h041], 64'hDEADBEEF);

      // Writeback then read back through memory.
      issue(0, 2'b10, 16'h2210, 32'h12345678, 4'b0000, 4'b0000, 128'h0, 0, 1'b1);
      wait_done_release();
      issue(2, 2'b01, 16'h2213, 32'h0, 4'b0000, 4'b0000, 128'h0, 0, 1'b1);
      wait_done_release();

      // Update broadcast leaves memory untouched.
      issue(3, 2'b11, 16'h0104, 32'h0000AAAA, 4'b0010, 4'b0000, 128'h0, 0, 1'b1);
      wait_done_release();
      check("upd_mem_unchanged", dut.r_mem[14'h041], 64'hDEADBEEF);

      // Randomized single transactions; own snoop bits are randomized too.
      for (int t = 0; t < 40; t++) begin
         fl = $urandom_range(0, 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
         a  = {pool[$urandom_range(0, 7)], 2'($urandom)};
         issue($urandom_range(0, 3), 2'($urandom_range(1, 3)), a, $urandom,
               4'($urandom_range(0, 15)), fl,
               {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
         wait_done_release();
         repeat ($urandom_range(0, 2)) @(posedge i_clock);
         #1;
      end

      // Reset during the memory phase of a writeback aborts it.
      a   = {pool[2], 2'b00};
      idx = int'(pool[2]);
      old = mm[idx];
      issue(0, 2'b10, a, ~old, 4'b0000, 4'b0000, 128'h0, 0, 1'b0);
      repeat (4) @(posedge i_clock);
      #2;
      i_reset = 1'b1;
      i_req   = '0;
      #1;
      check("abort_outputs_zero", {o_gnt, o_bus_rd, o_bus_upd, o_bus_addr, o_bus_data,
                                   o_bus_shared, o_done}, 64'd0);
      nd = n_done;
      repeat (2) @(posedge i_clock);
      #1 i_reset = 1'b0;
      repeat (10) @(posedge i_clock);
      #1;
      check("abort_no_done", n_done, nd);
      check("abort_mem_unchanged", dut.r_mem[pool[2]], old);

      // Four simultaneous reads: each transaction occupies 3+ML cycles plus one idle cycle.
      for (int c = 0; c < 4; c++) begin
         issue(c, 2'b01, {pool[c + 3], 2'b00}, 32'h0, 4'b0000, 4'b0000, 128'h0,
               (4 + ML) * c, 1'b1);
      end
      wait_done_release();
      // Cache 0 comes back immediately and must wait behind the other three.
      issue(0, 2'b01, {pool[7], 2'b00}, 32'h0, 4'b0000, 4'b0000, 128'h0,
            (4 + ML) * 3, 1'b1);
      for (int c = 0; c < 4; c++) wait_done_release();

      repeat (5) @(posedge i_clock);
      check("scoreboard_drained", sb.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
